// File: rtl/qdma_dsc_out_crd_snk.sv
// Sink end of the descriptor-out credit interface: buffers credit-gated descriptor
// beats in a local FIFO, drains them to a valid/ready consumer and batches credit returns.
module qdma_dsc_out_crd_snk #(
    parameter int DSC_W     = 256,
    parameter int QID_W     = 11,
    parameter int DEPTH     = 16,
    parameter int CRD_W     = 8,
    parameter int CRD_BATCH = 4,
    parameter int TO_CYC    = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       dsc_vld,
    input  logic [QID_W-1:0]           dsc_qid,
    input  logic [DSC_W-1:0]           dsc_data,
    output logic                       crd_vld,
    output logic [CRD_W-1:0]           crd_num,
    output logic                       out_vld,
    input  logic                       out_rdy,
    output logic [QID_W-1:0]           out_qid,
    output logic [DSC_W-1:0]           out_data,
    input  logic                       flush,
    output logic [$clog2(DEPTH):0]     fifo_cnt,
    output logic                       ovf_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int IW = $clog2(TO_CYC) + 1;
    localparam int EW = QID_W + DSC_W;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            state_r, state_s;
    logic [EW-1:0]     mem_r [DEPTH];
    logic [AW-1:0]     wr_ptr_r, wr_ptr_s;
    logic [AW-1:0]     rd_ptr_r, rd_ptr_s;
    logic [CW-1:0]     cnt_r, cnt_s;
    logic [CRD_W-1:0]  pend_r, pend_s;
    logic [IW-1:0]     idle_r, idle_s;
    logic              crd_vld_r, crd_vld_s;
    logic [CRD_W-1:0]  crd_num_r, crd_num_s;
    logic              ovf_err_r;
    logic              flush_d_r;

    logic              run_s;
    logic              pop_s;
    logic              room_s;
    logic              take_s;
    logic              push_s;
    logic              ovf_s;
    logic              release_s;
    logic [CRD_W-1:0]  add_s;

    // A beat "takes" a source credit whenever it would fit; a flush then discards it.
    assign run_s     = (state_r == ST_RUN);
    assign pop_s     = run_s & (cnt_r != '0) & out_rdy;
    assign room_s    = (cnt_r != CW'(DEPTH)) | pop_s;
    assign take_s    = run_s & dsc_vld & room_s;
    assign push_s    = take_s & ~flush;
    assign ovf_s     = dsc_vld & (~run_s | ~room_s);
    assign release_s = run_s & (pend_r != '0) &
                       ((pend_r >= CRD_W'(CRD_BATCH)) | (idle_r == IW'(TO_CYC - 1)) | flush_d_r);
    // On flush every held entry (including one popped this cycle) is freed exactly once.
    assign add_s     = flush ? (CRD_W'(cnt_r) + CRD_W'(take_s)) : CRD_W'(pop_s);

    // Next-state, pointer, occupancy and credit computation.
    always_comb begin
        state_s   = state_r;
        wr_ptr_s  = wr_ptr_r;
        rd_ptr_s  = rd_ptr_r;
        cnt_s     = cnt_r;
        pend_s    = pend_r;
        idle_s    = idle_r;
        crd_vld_s = 1'b0;
        crd_num_s = '0;
        case (state_r)
            ST_INIT: begin
                state_s   = ST_RUN;
                crd_vld_s = 1'b1;
                crd_num_s = CRD_W'(DEPTH);
            end
            ST_RUN: begin
                if (release_s) begin
                    crd_vld_s = 1'b1;
                    crd_num_s = pend_r;
                    pend_s    = add_s;
                    idle_s    = '0;
                end else begin
                    pend_s = pend_r + add_s;
                    if (pend_r == '0) begin
                        idle_s = '0;
                    end else begin
                        idle_s = idle_r + IW'(1);
                    end
                end
                if (flush) begin
                    cnt_s    = '0;
                    wr_ptr_s = '0;
                    rd_ptr_s = '0;
                end else begin
                    cnt_s = cnt_r + CW'(push_s) - CW'(pop_s);
                    if (push_s) begin
                        wr_ptr_s = wr_ptr_r + AW'(1);
                    end else begin
                        wr_ptr_s = wr_ptr_r;
                    end
                    if (pop_s) begin
                        rd_ptr_s = rd_ptr_r + AW'(1);
                    end else begin
                        rd_ptr_s = rd_ptr_r;
                    end
                end
            end
            default: begin
                state_s = ST_INIT;
            end
        endcase
    end

    // Control and credit state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_INIT;
            wr_ptr_r  <= '0;
            rd_ptr_r  <= '0;
            cnt_r     <= '0;
            pend_r    <= '0;
            idle_r    <= '0;
            crd_vld_r <= 1'b0;
            crd_num_r <= '0;
            ovf_err_r <= 1'b0;
            flush_d_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            wr_ptr_r  <= wr_ptr_s;
            rd_ptr_r  <= rd_ptr_s;
            cnt_r     <= cnt_s;
            pend_r    <= pend_s;
            idle_r    <= idle_s;
            crd_vld_r <= crd_vld_s;
            crd_num_r <= crd_num_s;
            ovf_err_r <= ovf_err_r | ovf_s;
            flush_d_r <= run_s & flush;
        end
    end

    // Descriptor storage; contents are only meaningful below the occupancy count.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {dsc_qid, dsc_data};
        end
    end

    assign crd_vld  = crd_vld_r;
    assign crd_num  = crd_num_r;
    assign out_vld  = (cnt_r != '0);
    assign out_qid  = mem_r[rd_ptr_r][EW-1:DSC_W];
    assign out_data = mem_r[rd_ptr_r][DSC_W-1:0];
    assign fifo_cnt = cnt_r;
    assign ovf_err  = ovf_err_r;

endmodule
